// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 datapath widths, shift cap and the align-stage state encoding.
package fp16_pkg;
    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int MANT_W    = 14;  // {hidden, frac[9:0], g, r, s}
    localparam int MAX_SHIFT = 13;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } align_state_t;
endpackage

// File: rtl/sticky_shr1.sv
// sticky_shr1: one-bit right shift of a GRS-extended mantissa, folding the dropped bit into sticky.
//   i_m : mantissa before the shift
//   o_m : mantissa after the shift, bit 0 = OR of old bits 1 and 0
module sticky_shr1
    import fp16_pkg::*;
(
    input  logic [MANT_W-1:0] i_m,
    output logic [MANT_W-1:0] o_m
);
    assign o_m = {1'b0, i_m[MANT_W-1:2], i_m[1] | i_m[0]};
endmodule

// File: rtl/align_mantissa.sv
// align_mantissa: restores hidden bits and right-aligns the smaller mantissa one bit per cycle.
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_in_valid / o_in_ready   : input handshake (ready only while idle)
//   i_moves, i_swap, i_exp    : exponent difference, swap flag, common exponent
//   i_am, i_bm                : fractions of the larger / smaller operand
//   i_sign_a, i_sign_b        : original operand signs
//   o_out_valid / i_out_ready : output handshake
//   o_exp_out, o_big_m, o_small_m, o_sign_big, o_sign_small : aligned result
module align_mantissa #(
    parameter int MAX_SHIFT = fp16_pkg::MAX_SHIFT
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [fp16_pkg::EXP_W-1:0]  i_moves,
    input  logic                        i_swap,
    input  logic [fp16_pkg::EXP_W-1:0]  i_exp,
    input  logic [fp16_pkg::FRAC_W-1:0] i_am,
    input  logic [fp16_pkg::FRAC_W-1:0] i_bm,
    input  logic                        i_sign_a,
    input  logic                        i_sign_b,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [fp16_pkg::EXP_W-1:0]  o_exp_out,
    output logic [fp16_pkg::MANT_W-1:0] o_big_m,
    output logic [fp16_pkg::MANT_W-1:0] o_small_m,
    output logic                        o_sign_big,
    output logic                        o_sign_small
);
    import fp16_pkg::*;

    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    align_state_t       r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [EXP_W-1:0]   r_exp;
    logic [MANT_W-1:0]  r_big, r_small, w_shifted;
    logic               r_sign_big, r_sign_small;
    logic [EXP_W-1:0]   w_small_exp, w_s;
    logic [CNT_W-1:0]   w_n;
    logic               w_accept;

    assign w_accept    = (r_state == IDLE) && i_in_valid;
    assign w_small_exp = i_exp - i_moves;
    // A subnormal smaller operand sits at effective exponent 1, so it needs one shift less.
    assign w_s = (w_small_exp == '0 && i_exp != '0) ? i_moves - EXP_W'(1) : i_moves;
    assign w_n = (w_s > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : w_s[CNT_W-1:0];

    sticky_shr1 u_shr (
        .i_m (r_small),
        .o_m (w_shifted)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = i_in_valid ? ((w_n != '0) ? SHIFT : DONE) : IDLE;
            SHIFT:   w_next = (r_cnt == CNT_W'(1)) ? DONE : SHIFT;
            DONE:    w_next = i_out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_exp        <= '0;
            r_big        <= '0;
            r_small      <= '0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
        end else if (w_accept) begin
            r_cnt        <= w_n;
            r_exp        <= i_exp;
            r_big        <= {i_exp != '0, i_am, 3'b000};
            r_small      <= {w_small_exp != '0, i_bm, 3'b000};
            r_sign_big   <= i_swap ? i_sign_b : i_sign_a;
            r_sign_small <= i_swap ? i_sign_a : i_sign_b;
        end else if (r_state == SHIFT) begin
            r_small <= w_shifted;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign o_in_ready   = (r_state == IDLE);
    assign o_out_valid  = (r_state == DONE);
    assign o_exp_out    = r_exp;
    assign o_big_m      = r_big;
    assign o_small_m    = r_small;
    assign o_sign_big   = r_sign_big;
    assign o_sign_small = r_sign_small;
endmodule

// File: doc/align_mantissa.md
# align_mantissa

Alignment stage of the binary16 adder datapath, directly downstream of the operand-arrangement stage. It takes the swapped operands (larger-exponent mantissa, smaller-exponent mantissa, common exponent, shift distance) and restores the hidden bits. It then right-shifts the smaller mantissa one bit per cycle into a guard/round/sticky-extended 14-bit format and presents both aligned mantissas to the add/subtract stage over a valid/ready handshake.

## Interface
Parameters:
- MAX_SHIFT, 13, shift-iteration cap; after 13 shifts every significant bit has collapsed into sticky.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  arranged operands present.
- in_ready  out  1  block can accept (high only in IDLE).
- moves  in  5  exponent difference from the arrangement stage.
- swap  in  1  operands were exchanged upstream.
- exp  in  5  larger (common) exponent.
- am  in  10  fraction of the larger operand.
- bm  in  10  fraction of the smaller operand.
- sign_a, sign_b  in  1 each  original signs of operands A and B.
- out_valid  out  1  aligned result present.
- out_ready  in  1  downstream accepts.
- exp_out  out  5  common exponent, registered copy of exp.
- big_m  out  14  {hidden, frac[9:0], g, r, s} of the larger operand.
- small_m  out  14  aligned smaller operand, same format.
- sign_big, sign_small  out  1 each  signs after swap: swap=1 gives sign_big=sign_b; swap=0 gives sign_big=sign_a.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1.
  - On in_valid, capture the inputs.
  - big_m = {exp!=0, am, 3'b000}.
  - small_exp = exp - moves.
  - small_m = {small_exp!=0, bm, 3'b000}.
  - Effective shift: s = moves - 1 when small_exp==0 and exp!=0 (subnormal effective exponent is 1); otherwise s = moves.
  - Iteration count: n = min(s, MAX_SHIFT).
  - Transition: to SHIFT if n>0, else to DONE.
- SHIFT: each cycle, small_m <= {1'b0, small_m[13:2], small_m[1]|small_m[0]} and the counter decrements. Transition to DONE in the cycle the counter reaches 0.
- DONE: out_valid=1; all outputs hold stable until out_ready. Transition to IDLE on out_valid && out_ready.
- Cancel input (upstream zeros everything: moves=0, exp=0, am=bm=0): no special case; it yields big_m=small_m=0 in DONE.
- exp_out, signs and big_m never change after capture.

## Timing
- Reset (rst_n low at an edge): state=IDLE, in_ready=1 after reset, out_valid=0, exp_out=0, big_m=0, small_m=0, sign_big=0, sign_small=0, counter=0.
- Accept at edge T (in_valid && in_ready): out_valid rises at T+1+n.
  - Minimum latency 1 cycle (n=0).
  - Maximum latency 14 cycles (n=13).
- in_ready is low from T+1 until the cycle after the output handshake completes. There is no same-cycle accept/retire overlap: throughput is one operation per 2+n cycles.
- Backpressure: out_valid stays high and the outputs stay stable for as long as out_ready is low.
- Reset asserted mid-SHIFT or in DONE: the operation is aborted and all outputs take their reset values at that edge. No output is ever produced for the aborted operation.
- moves of 13 or more: exactly 13 iterations, with the sticky bit accumulating the OR of all shifted-out bits.

## Structure
- Shared package fp16_pkg holds: EXP_W=5, FRAC_W=10, MANT_W=14 (hidden+frac+GRS), MAX_SHIFT=13, and the state enum {IDLE, SHIFT, DONE}. The downstream add stage reuses MANT_W and the GRS layout.
- One sub-module, sticky_shr1: combinational 1-bit right shift of a MANT_W vector that ORs the outgoing bit into bit 0. It is instantiated once in the SHIFT datapath.

## Test plan
- 1.0 + 0.5 (exp=15, moves=1, am=bm=0, swap=0) -> at T+2: big_m=0x2000, small_m=0x1000, exp_out=15.
- Equal operands 0x3C00 + 0x3C00 (moves=0) -> at T+1: big_m=small_m=0x2000.
- exp=25, moves=20, bm=0x3FF -> exactly 13 SHIFT cycles, out_valid at T+14, small_m=0x0001 (sticky only).
- Subnormal: exp=1, moves=1, bm=0x200 (small_exp=0, s=0) -> at T+1: small_m=0x1000, hidden bit 0.
- Backpressure: out_ready low for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout, handshake completes on the first cycle out_ready=1; IDLE on the next cycle.
- Reset mid-shift (rst_n low 3 cycles into a 13-shift op) -> next edge: out_valid=0, all outputs 0, in_ready=1 after release; a new operation then completes normally.
